// File: rtl/cordic_scheduler.sv
// cordic_scheduler
//
// Shares one cordic_pipeline between two requesters. Angles are issued into
// the pipeline under round-robin arbitration, a tag shift register remembers
// which port owns every in-flight operand, and each cosine result is steered
// back to its owner. If the owner of the result at the pipeline head is not
// ready, the pipeline and the tag register freeze together through clk_en.
//
// Handshake semantics (both request and response sides): a transfer happens
// on a rising clock edge where valid and ready are both high. reqX_ready is
// the grant and is only high while reqX_valid is high. rspX_valid does not
// depend on rspX_ready, and a stalled result stays on rspX_data until taken.
//
// Ports:
//   clock, aclr_n            clock, asynchronous active-low reset
//   req0_*/req1_*            request side (valid, data in; ready out)
//   rsp0_*/rsp1_*            response side (valid, data out; ready in)
//   pipe_aclr, pipe_clk_en,  drive the shared cordic_pipeline
//   pipe_dataa, pipe_result  operand to / result from the pipeline
//   in_flight                number of operands currently in the pipeline
module cordic_scheduler #(
    parameter int LATENCY = 16,
    parameter int WIDTH   = 32
) (
    input  logic                         clock,
    input  logic                         aclr_n,
    input  logic                         req0_valid,
    input  logic [WIDTH-1:0]             req0_data,
    output logic                         req0_ready,
    input  logic                         req1_valid,
    input  logic [WIDTH-1:0]             req1_data,
    output logic                         req1_ready,
    output logic                         rsp0_valid,
    output logic [WIDTH-1:0]             rsp0_data,
    input  logic                         rsp0_ready,
    output logic                         rsp1_valid,
    output logic [WIDTH-1:0]             rsp1_data,
    input  logic                         rsp1_ready,
    output logic                         pipe_aclr,
    output logic                         pipe_clk_en,
    output logic [WIDTH-1:0]             pipe_dataa,
    input  logic [WIDTH-1:0]             pipe_result,
    output logic [$clog2(LATENCY+1)-1:0] in_flight
);

    localparam int CW   = $clog2(LATENCY + 1);
    localparam int HEAD = LATENCY - 1;

    // Tag shift register: vld marks a real operand, dst its owning port.
    logic [LATENCY-1:0] vld;
    logic [LATENCY-1:0] dst;
    logic               run;         // low for the first edge after reset release
    logic               last_grant;  // port granted on the most recent accept
    logic [CW-1:0]      in_flight_q;

    logic head_vld;
    logic head_dst;
    logic head_ready;
    logic stall;
    logic can_grant;
    logic grant0;
    logic grant1;
    logic accept;
    logic handshake;

    assign head_vld   = run & vld[HEAD];
    assign head_dst   = dst[HEAD];
    assign head_ready = head_dst ? rsp1_ready : rsp0_ready;

    // A result waiting on an unready owner freezes everything behind it.
    assign stall       = head_vld & ~head_ready;
    assign pipe_clk_en = ~stall;

    assign rsp0_valid = head_vld & ~head_dst;
    assign rsp1_valid = head_vld &  head_dst;
    assign rsp0_data  = pipe_result;
    assign rsp1_data  = pipe_result;
    assign handshake  = (rsp0_valid & rsp0_ready) | (rsp1_valid & rsp1_ready);

    // Round robin: on a tie the port opposite last_grant wins.
    assign can_grant = run & ~stall;
    assign grant0    = can_grant & req0_valid & (~req1_valid |  last_grant);
    assign grant1    = can_grant & req1_valid & (~req0_valid | ~last_grant);
    assign accept    = grant0 | grant1;

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // With no grant a zero operand enters as a bubble (vld[0] loads 0).
    always_comb begin
        pipe_dataa = '0;
        if (grant0) begin
            pipe_dataa = req0_data;
        end else if (grant1) begin
            pipe_dataa = req1_data;
        end
    end

    // The pipeline clears asynchronously together with this block.
    assign pipe_aclr = ~aclr_n;
    assign in_flight = in_flight_q;

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            vld         <= '0;
            dst         <= '0;
            run         <= 1'b0;
            last_grant  <= 1'b1;
            in_flight_q <= '0;
        end else begin
            run <= 1'b1;
            if (pipe_clk_en) begin
                vld <= {vld[LATENCY-2:0], accept};
                dst <= {dst[LATENCY-2:0], grant1};
            end
            if (accept) begin
                last_grant <= grant1;
            end
            case ({accept, handshake})
                2'b10:   in_flight_q <= in_flight_q + CW'(1);
                2'b01:   in_flight_q <= in_flight_q - CW'(1);
                default: in_flight_q <= in_flight_q;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_scheduler.sv
// Bench for cordic_scheduler with LATENCY=4. A stand-in pipeline (fixed
// LATENCY-stage register applying cfun) sits behind the scheduler. Expected
// behaviour comes from an operation-level model: a queue of in-flight
// operations, each carrying the number of enabled edges it has seen.
module tb_cordic_scheduler;

    localparam int LAT = 4;
    localparam int W   = 32;
    localparam int CW  = $clog2(LAT + 1);

    logic          clock;
    logic          aclr_n;
    logic          req0_valid, req1_valid;
    logic [W-1:0]  req0_data, req1_data;
    logic          req0_ready, req1_ready;
    logic          rsp0_valid, rsp1_valid;
    logic [W-1:0]  rsp0_data, rsp1_data;
    logic          rsp0_ready, rsp1_ready;
    logic          pipe_aclr, pipe_clk_en;
    logic [W-1:0]  pipe_dataa, pipe_result;
    logic [CW-1:0] in_flight;

    cordic_scheduler #(.LATENCY(LAT), .WIDTH(W)) dut (
        .clock      (clock),
        .aclr_n     (aclr_n),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .rsp0_valid (rsp0_valid),
        .rsp0_data  (rsp0_data),
        .rsp0_ready (rsp0_ready),
        .rsp1_valid (rsp1_valid),
        .rsp1_data  (rsp1_data),
        .rsp1_ready (rsp1_ready),
        .pipe_aclr  (pipe_aclr),
        .pipe_clk_en(pipe_clk_en),
        .pipe_dataa (pipe_dataa),
        .pipe_result(pipe_result),
        .in_flight  (in_flight)
    );

    // ---------------- clock ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- stand-in cordic pipeline ----------------
    function automatic logic [W-1:0] cfun(input logic [W-1:0] x);
        return {x[15:0], x[31:16]} ^ 32'h1234_5678;
    endfunction

    logic [W-1:0] pq [LAT];
    always @(posedge clock or posedge pipe_aclr) begin
        if (pipe_aclr) begin
            for (int i = 0; i < LAT; i++) pq[i] <= '0;
        end else if (pipe_clk_en) begin
            pq[0] <= cfun(pipe_dataa);
            for (int i = 1; i < LAT; i++) pq[i] <= pq[i-1];
        end
    end
    assign pipe_result = pq[LAT-1];

    // ---------------- scoreboard / model ----------------
    typedef struct {
        logic         port;
        logic [W-1:0] data;
        int           age;   // enabled edges seen, counting the accept edge
    } op_t;

    op_t exp_q[$];
    bit  m_run;
    bit  m_last;

    int n_cmp;
    int n_err;

    logic          s_req0_ready, s_req1_ready, s_rsp0_valid, s_rsp1_valid;
    logic          s_clk_en;
    logic [W-1:0]  s_rsp0_data, s_rsp1_data;
    logic [CW-1:0] s_in_flight;
    int            hs1_cnt;
    int            max_if;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_run  = 1'b0;
        m_last = 1'b1;
    endtask

    // One clock cycle: inputs are already applied. Outputs are sampled and
    // checked against the model at the falling edge; the model advances at
    // the rising edge; returns 1 time unit after it.
    task automatic tick();
        bit           e_head, e_stall, e_acc, e_port, can;
        logic [W-1:0] e_data;
        op_t          t;
        @(negedge clock);
        s_req0_ready = req0_ready;
        s_req1_ready = req1_ready;
        s_rsp0_valid = rsp0_valid;
        s_rsp1_valid = rsp1_valid;
        s_rsp0_data  = rsp0_data;
        s_rsp1_data  = rsp1_data;
        s_clk_en     = pipe_clk_en;
        s_in_flight  = in_flight;
        if (s_rsp1_valid && rsp1_ready) hs1_cnt++;
        if (int'(s_in_flight) > max_if) max_if = int'(s_in_flight);

        e_head  = aclr_n && m_run && exp_q.size() > 0 && exp_q[0].age >= LAT;
        e_port  = 1'b0;
        e_stall = 1'b0;
        if (e_head) e_stall = exp_q[0].port ? !rsp1_ready : !rsp0_ready;
        can   = aclr_n && m_run && !e_stall;
        e_acc = 1'b0;
        if (can && req0_valid && req1_valid) begin
            e_acc = 1'b1;
            e_port = m_last ? 1'b0 : 1'b1;
        end else if (can && req0_valid) begin
            e_acc = 1'b1;
            e_port = 1'b0;
        end else if (can && req1_valid) begin
            e_acc = 1'b1;
            e_port = 1'b1;
        end
        e_data = e_acc ? (e_port ? req1_data : req0_data) : '0;

        chk("req0_ready", 32'(s_req0_ready), 32'(e_acc && !e_port));
        chk("req1_ready", 32'(s_req1_ready), 32'(e_acc && e_port));
        chk("rsp0_valid", 32'(s_rsp0_valid), 32'(e_head && !exp_q[0].port));
        chk("rsp1_valid", 32'(s_rsp1_valid), 32'(e_head && exp_q[0].port));
        chk("pipe_clk_en", 32'(s_clk_en), 32'(!e_stall));
        chk("pipe_dataa", pipe_dataa, e_data);
        chk("pipe_aclr", 32'(pipe_aclr), 32'(!aclr_n));
        chk("in_flight", 32'(s_in_flight), 32'(exp_q.size()));
        if (e_head && !exp_q[0].port) chk("rsp0_data", s_rsp0_data, cfun(exp_q[0].data));
        if (e_head && exp_q[0].port)  chk("rsp1_data", s_rsp1_data, cfun(exp_q[0].data));

        @(posedge clock);
        if (!aclr_n) begin
            model_reset();
        end else begin
            if (e_head && !e_stall) void'(exp_q.pop_front());
            if (!e_stall) begin
                for (int i = 0; i < exp_q.size(); i++) begin
                    t = exp_q[i];
                    t.age++;
                    exp_q[i] = t;
                end
            end
            if (e_acc) begin
                t.port = e_port;
                t.data = e_data;
                t.age  = 1;
                exp_q.push_back(t);
                m_last = e_port;
            end
            m_run = 1'b1;
        end
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_data  = '0;
        req1_data  = '0;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
    endtask

    // ---------------- contention vector table ----------------
    typedef struct {
        logic r0v, r1v;     // request valids
        logic e0r, e1r;     // expected grants
        logic e0v, e1v;     // expected response valids
        int   eif;          // expected in_flight
    } vec_t;

    vec_t tbl [12];

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        hs1_cnt = 0;
        max_if  = 0;
        model_reset();

        // First row is the cycle right after reset release (run still low);
        // then both ports request for six cycles and alternate 0,1,0,...
        tbl[0]  = '{1, 1, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 1, 1, 0, 0, 0, 0};
        tbl[2]  = '{1, 1, 0, 1, 0, 0, 1};
        tbl[3]  = '{1, 1, 1, 0, 0, 0, 2};
        tbl[4]  = '{1, 1, 0, 1, 0, 0, 3};
        tbl[5]  = '{1, 1, 1, 0, 1, 0, 4};
        tbl[6]  = '{1, 1, 0, 1, 0, 1, 4};
        tbl[7]  = '{0, 0, 0, 0, 1, 0, 4};
        tbl[8]  = '{0, 0, 0, 0, 0, 1, 3};
        tbl[9]  = '{0, 0, 0, 0, 1, 0, 2};
        tbl[10] = '{0, 0, 0, 0, 0, 1, 1};
        tbl[11] = '{0, 0, 0, 0, 0, 0, 0};

        // ---------------- reset ----------------
        aclr_n = 1'b0;
        idle_inputs();
        tick();
        tick();
        chk("reset_in_flight", 32'(in_flight), 32'd0);
        aclr_n = 1'b1;

        // ---------------- contention table ----------------
        for (int i = 0; i < 12; i++) begin
            req0_valid = tbl[i].r0v;
            req1_valid = tbl[i].r1v;
            req0_data  = 32'h1000_0000 + i;
            req1_data  = 32'h2000_0000 + i;
            tick();
            chk($sformatf("tbl%0d_req0_ready", i), 32'(s_req0_ready), 32'(tbl[i].e0r));
            chk($sformatf("tbl%0d_req1_ready", i), 32'(s_req1_ready), 32'(tbl[i].e1r));
            chk($sformatf("tbl%0d_rsp0_valid", i), 32'(s_rsp0_valid), 32'(tbl[i].e0v));
            chk($sformatf("tbl%0d_rsp1_valid", i), 32'(s_rsp1_valid), 32'(tbl[i].e1v));
            chk($sformatf("tbl%0d_in_flight", i), 32'(s_in_flight), 32'(tbl[i].eif));
        end
        idle_inputs();

        // ---------------- single request, data 0 ----------------
        req0_valid = 1'b1;
        tick();
        chk("single_ready", 32'(s_req0_ready), 32'd1);
        chk("single_if0", 32'(s_in_flight), 32'd0);
        req0_valid = 1'b0;
        tick();
        chk("single_if1", 32'(s_in_flight), 32'd1);
        tick();
        tick();
        tick();
        chk("single_rsp_valid", 32'(s_rsp0_valid), 32'd1);
        chk("single_rsp_data", s_rsp0_data, cfun(32'h0));
        tick();
        chk("single_rsp_gone", 32'(s_rsp0_valid), 32'd0);
        chk("single_if_end", 32'(s_in_flight), 32'd0);

        // ---------------- back-pressure ----------------
        req0_valid = 1'b1;
        req0_data  = 32'hDEAD_BEEF;
        rsp0_ready = 1'b0;
        tick();
        chk("bp_accept", 32'(s_req0_ready), 32'd1);
        req0_valid = 1'b0;
        tick();
        tick();
        tick();
        req1_valid = 1'b1;
        req1_data  = 32'h0BAD_F00D;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("bp_hold%0d_valid", k), 32'(s_rsp0_valid), 32'd1);
            chk($sformatf("bp_hold%0d_clk_en", k), 32'(s_clk_en), 32'd0);
            chk($sformatf("bp_hold%0d_req1_ready", k), 32'(s_req1_ready), 32'd0);
            chk($sformatf("bp_hold%0d_data", k), s_rsp0_data, cfun(32'hDEAD_BEEF));
        end
        rsp0_ready = 1'b1;
        tick();
        chk("bp_release_valid", 32'(s_rsp0_valid), 32'd1);
        chk("bp_release_clk_en", 32'(s_clk_en), 32'd1);
        chk("bp_release_grant", 32'(s_req1_ready), 32'd1);
        req1_valid = 1'b0;
        tick();
        chk("bp_no_dup", 32'(s_rsp0_valid), 32'd0);
        for (int k = 0; k < 5; k++) tick();

        // ---------------- back-to-back port-1 stream ----------------
        hs1_cnt = 0;
        max_if  = 0;
        for (int k = 0; k < 20; k++) begin
            req1_valid = 1'b1;
            req1_data  = $urandom;
            tick();
        end
        idle_inputs();
        for (int k = 0; k < LAT; k++) tick();
        chk("b2b_max_in_flight", 32'(max_if), 32'(LAT));
        chk("b2b_responses", 32'(hs1_cnt), 32'd20);
        tick();
        tick();

        // ---------------- reset mid-flight ----------------
        req1_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req1_data = 32'h3000_0000 + k;
            tick();
        end
        req1_valid = 1'b0;
        #2;
        chk("mid_in_flight_3", 32'(in_flight), 32'd3);
        aclr_n = 1'b0;
        #1;
        chk("mid_pipe_aclr", 32'(pipe_aclr), 32'd1);
        chk("mid_in_flight_0", 32'(in_flight), 32'd0);
        chk("mid_rsp_valid", 32'({rsp1_valid, rsp0_valid}), 32'd0);
        model_reset();
        tick();
        tick();
        aclr_n     = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_data  = 32'h4000_0000;
        req1_data  = 32'h5000_0000;
        tick();
        chk("post_reset_ready", 32'({s_req1_ready, s_req0_ready}), 32'd0);
        tick();
        chk("post_reset_tie_p0", 32'(s_req0_ready), 32'd1);
        chk("post_reset_tie_p1", 32'(s_req1_ready), 32'd0);
        idle_inputs();
        for (int k = 0; k < 6; k++) tick();

        // ---------------- randomized traffic ----------------
        for (int k = 0; k < 400; k++) begin
            req0_valid = 1'($urandom_range(0, 1));
            req1_valid = 1'($urandom_range(0, 1));
            req0_data  = $urandom;
            req1_data  = $urandom;
            rsp0_ready = ($urandom_range(0, 3) != 0);
            rsp1_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        idle_inputs();
        for (int k = 0; k < 3 * LAT; k++) tick();
        chk("drain_in_flight", 32'(in_flight), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
